// File: rtl/x3q16_memctl.sv
// Memory responder for the x3q16 core: instruction pointer, single-port word RAM,
// programmable wait states, out-of-range flagging and a side load port.
module x3q16_memctl #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 request,
    input  logic [1:0]           request_type,
    input  logic [15:0]          request_address,
    input  logic [15:0]          store_data,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [15:0]          load_data,
    output logic [15:0]          memory_in,
    output logic [15:0]          current_address,
    output logic                 memory_ready,
    output logic                 memory_critical
);

    localparam int         DEPTH     = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT  = 4'(WAIT_STATES);
    localparam logic [1:0] REQ_NEXT  = 2'b00;
    localparam logic [1:0] REQ_READ  = 2'b01;
    localparam logic [1:0] REQ_WRITE = 2'b10;
    localparam logic [1:0] REQ_JUMP  = 2'b11;

    typedef enum logic {
        BUSY  = 1'b0,
        READY = 1'b1
    } state_t;

    // An address is implemented only if no bit at or above ADDR_BITS is set.
    function automatic logic in_range(input logic [15:0] addr);
        return (addr >> ADDR_BITS) == 16'd0;
    endfunction

    logic [15:0] mem [DEPTH];

    state_t      state_r, state_s;
    logic [15:0] pc_r, pc_s;
    logic [15:0] target_r, target_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [15:0] data_r, data_s;
    logic [15:0] addr_r, addr_s;
    logic        ready_r, ready_s;
    logic        crit_r, crit_s;
    logic        wr_en_s;
    logic [15:0] pc_inc_s;

    assign pc_inc_s        = pc_r + 16'd1;
    assign memory_in       = data_r;
    assign current_address = addr_r;
    assign memory_ready    = ready_r;
    assign memory_critical = crit_r;

    // Next-state and response computation; critical is a pulse, so it defaults low.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        target_s = target_r;
        cnt_s    = cnt_r;
        data_s   = data_r;
        addr_s   = addr_r;
        ready_s  = ready_r;
        crit_s   = 1'b0;
        wr_en_s  = 1'b0;
        case (state_r)
            READY: begin
                if (request) begin
                    ready_s = 1'b0;
                    cnt_s   = CNT_INIT;
                    state_s = BUSY;
                    case (request_type)
                        REQ_NEXT: begin
                            pc_s     = pc_inc_s;
                            target_s = pc_inc_s;
                        end
                        REQ_READ: begin
                            target_s = request_address;
                        end
                        REQ_WRITE: begin
                            wr_en_s  = in_range(request_address);
                            crit_s   = ~in_range(request_address);
                            pc_s     = pc_inc_s;
                            target_s = pc_inc_s;
                        end
                        REQ_JUMP: begin
                            pc_s     = request_address;
                            target_s = request_address;
                        end
                        default: begin
                            target_s = target_r;
                        end
                    endcase
                end else begin
                    state_s = READY;
                end
            end
            BUSY: begin
                if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
                    // Unimplemented addresses read as zero and raise critical with ready.
                    if (in_range(target_r)) begin
                        data_s = mem[target_r[ADDR_BITS-1:0]];
                        crit_s = 1'b0;
                    end else begin
                        data_s = 16'h0000;
                        crit_s = 1'b1;
                    end
                    addr_s  = target_r;
                    ready_s = 1'b1;
                    state_s = READY;
                end
            end
            default: begin
                state_s = BUSY;
                cnt_s   = CNT_INIT;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= BUSY;
            pc_r     <= 16'h0000;
            target_r <= 16'h0000;
            cnt_r    <= CNT_INIT;
            data_r   <= 16'h0000;
            addr_r   <= 16'h0000;
            ready_r  <= 1'b0;
            crit_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            target_r <= target_s;
            cnt_r    <= cnt_s;
            data_r   <= data_s;
            addr_r   <= addr_s;
            ready_r  <= ready_s;
            crit_r   <= crit_s;
        end
    end

    // RAM write port; the load port is applied last so it wins a same-address clash.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[request_address[ADDR_BITS-1:0]] <= store_data;
        end
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

endmodule

// File: doc/x3q16_memctl.md
# x3q16_memctl

Memory responder for the x3q16 core: owns the instruction pointer and a single-port word RAM, and answers the core's `request`/`request_type` bus with `memory_in`, `current_address` and `memory_ready`. It serves the four request kinds (next instruction, data read, write-then-next, jump), inserts a programmable number of wait states, and flags out-of-range accesses on `memory_critical`. A side load port fills the RAM before or while the core runs.

## Interface
- `ADDR_BITS`, 8: implemented RAM depth is 2^ADDR_BITS 16-bit words at addresses 0..2^ADDR_BITS-1.
- `WAIT_STATES`, 1: extra busy cycles per access (0..15).

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `request`  in  1  one-cycle strobe from core; sampled only while `memory_ready`=1.
- `request_type`  in  2  00 next instruction, 01 read, 10 write then next instruction, 11 jump.
- `request_address`  in  16  read/write/jump target.
- `store_data`  in  16  write data for type 10.
- `load_en`  in  1  side-port write strobe.
- `load_addr`  in  ADDR_BITS  side-port address.
- `load_data`  in  16  side-port data.
- `memory_in`  out  16  word at `current_address`.
- `current_address`  out  16  address of the word on `memory_in`.
- `memory_ready`  out  1  response valid, ready for a request.
- `memory_critical`  out  1  one-cycle pulse on an out-of-range access.

## Operation
- Registers: `pc` (16), `target` (16), `cnt` (4), state ∈ {BUSY, READY}.
- Reset values: `pc`=0, `target`=0, `cnt`=WAIT_STATES, state=BUSY, `memory_in`=0, `current_address`=0, `memory_ready`=0, `memory_critical`=0. The first response after reset therefore delivers word 0 without a request.
- READY, `request`=1 (edge E0): `memory_ready`<=0, `cnt`<=WAIT_STATES, state<=BUSY, and by type:
  - 00: `pc`<=`pc`+1; `target`<=`pc`+1.
  - 01: `target`<=`request_address`; `pc` unchanged.
  - 10: RAM[`request_address`]<=`store_data`; `pc`<=`pc`+1; `target`<=`pc`+1.
  - 11: `pc`<=`request_address`; `target`<=`request_address`.
- READY, `request`=0: hold all outputs.
- BUSY: `request` is ignored. If `cnt`≠0, decrement it. If `cnt`=0: `memory_in`<=RAM[`target`], `current_address`<=`target`, `memory_ready`<=1, state<=READY.
- `pc`+1 wraps modulo 2^16 (FFFF→0000).
- Out of range means any address bit at or above ADDR_BITS is set.
  - Out-of-range write (type 10): dropped, and `memory_critical`=1 for the cycle after E0.
  - Out-of-range response `target`: `memory_in`=0000, and `memory_critical`=1 in the same cycle `memory_ready` rises.
  - `memory_critical` is otherwise 0; it never stays high for more than one cycle per event.
- Load port: when `load_en`=1, RAM[`load_addr`]<=`load_data` at the edge, in any state. If it hits the same address as a type-10 write in the same cycle, `load_data` wins.
- The core detects a new word only by a change in `current_address`. Two consecutive responses to the same address are invisible to it. Software must not do that; the block does not compensate.
- Reset asserted mid-access aborts the access. No RAM write occurs unless E0 had already passed. RAM contents are not cleared by reset.

## Timing
- A request sampled at E0 produces `memory_ready`=0 for exactly WAIT_STATES+1 cycles. `memory_in`/`current_address` update together with `memory_ready` rising at edge E0+WAIT_STATES+1.
- Throughput: one access per WAIT_STATES+2 cycles at most.
- A type-10 write is committed at E0, so a following read of that address returns the new data. This includes type 10 whose write address equals `pc`+1.
- `memory_in`, `current_address` and `memory_ready` are registered; no combinational path from inputs to outputs.

## Test plan
- Preload RAM[0..3]=1111,2222,3333,4444; release reset (WAIT_STATES=1) -> after 2 cycles `memory_ready`=1, `current_address`=0000, `memory_in`=1111; type 00 ×3 -> addresses 1,2,3 in order, each 2 cycles after its request.
- `pc`=2, type 01 to 0010 (RAM=ABCD) -> `current_address`=0010, `memory_in`=ABCD; then type 00 -> `current_address`=0003, `memory_in`=4444.
- `pc`=1, type 10 address 0002 data BEEF -> response `current_address`=0002, `memory_in`=BEEF.
- Type 11 to 0040 -> `current_address`=0040; the next type 00 returns 0041.
- ADDR_BITS=8, type 01 to 0100 -> `memory_in`=0000 and a one-cycle `memory_critical` with ready; type 10 to 0200 -> critical pulse, RAM unchanged.
- `request` pulsed while BUSY -> ignored, `pc` unchanged. Reset asserted during BUSY -> all outputs return to reset values immediately, and word 0 is re-served.
